// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with a two-entry output buffer; optional illegal check under DECODE_ILLEGAL_CHK_EN
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_U    = 3'd2;
  localparam logic [2:0] FMT_J    = 3'd3;
  localparam logic [2:0] FMT_B    = 3'd4;
  localparam logic [2:0] FMT_S    = 3'd5;
  localparam logic [2:0] FMT_R    = 3'd6;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [PC_W-1:0] pc;
`ifdef DECODE_ILLEGAL_CHK_EN
    logic            illegal;
`endif
  } beat_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t      state, state_nx;
  beat_t       dec, main_q, skid_q;
  logic [31:0] imm32;
  logic        accept, consume;
  logic        load_main, load_skid, shift_skid;

  always_comb begin
    dec        = '0;
    imm32      = '0;
    dec.opcode = in_instr[6:0];
    dec.rd     = in_instr[11:7];
    dec.func3  = in_instr[14:12];
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.func7  = in_instr[31:25];
    dec.pc     = in_pc;
    dec.fmt    = FMT_NONE;
    case (in_instr[6:0])
      OP_JALR, OP_LOAD, OP_IMM: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_OP:   dec.fmt = FMT_R;
      default: dec.fmt = FMT_NONE;
    endcase
    dec.imm = XLEN'($signed(imm32));
`ifdef DECODE_ILLEGAL_CHK_EN
    dec.illegal = (in_instr[1:0] != 2'b11);
    case (in_instr[6:0])
      OP_JALR:   if (dec.func3 != 3'b000) dec.illegal = 1'b1;
      OP_BRANCH: if (dec.func3 == 3'b010 || dec.func3 == 3'b011) dec.illegal = 1'b1;
      OP_LOAD:   if (dec.func3 == 3'b011 || dec.func3 == 3'b110 || dec.func3 == 3'b111)
                   dec.illegal = 1'b1;
      OP_STORE:  if (dec.func3 > 3'b010) dec.illegal = 1'b1;
      OP_OP:     if (!(dec.func7 == 7'b0000000 ||
                       (dec.func7 == 7'b0100000 &&
                        (dec.func3 == 3'b000 || dec.func3 == 3'b101))))
                   dec.illegal = 1'b1;
      OP_IMM, OP_LUI, OP_AUIPC, OP_JAL: ;
      default:   dec.illegal = 1'b1;
    endcase
`endif
  end

  // in_ready comes straight off the state register, never from out_ready
  assign in_ready  = (state != S_TWO);
  assign out_valid = (state != S_EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_nx   = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    case (state)
      S_EMPTY: if (accept) begin
        state_nx  = S_ONE;
        load_main = 1'b1;
      end
      S_ONE: begin
        if (accept && consume) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_nx  = S_TWO;
          load_skid = 1'b1;
        end else if (consume) begin
          state_nx = S_EMPTY;
        end
      end
      S_TWO: if (consume) begin
        state_nx   = S_ONE;
        shift_skid = 1'b1;
      end
      default: state_nx = S_EMPTY;
    endcase
    if (flush) state_nx = S_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (load_main)       main_q <= dec;
    else if (shift_skid) main_q <= skid_q;
    if (load_skid)       skid_q <= dec;
  end

  assign out_opcode = main_q.opcode;
  assign out_func3  = main_q.func3;
  assign out_func7  = main_q.func7;
  assign out_rs1    = main_q.rs1;
  assign out_rs2    = main_q.rs2;
  assign out_rd     = main_q.rd;
  assign out_imm    = main_q.imm;
  assign out_fmt    = main_q.fmt;
  assign out_pc     = main_q.pc;

`ifdef DECODE_ILLEGAL_CHK_EN
  // Gated by out_valid so the unreset datapath cannot leak a flag after reset
  assign out_illegal = main_q.illegal & out_valid;
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage at XLEN=64
module tb_decode_stage;

  localparam int XLEN = 64;
  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [PC_W-1:0] out_pc;
  logic            out_illegal;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_ill;

  decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_illegal", out_illegal, 0);
    rst = 1'b0;

    // addi x1,x0,5
    out_ready = 1'b1;
    drive(1'b1, 32'h00500093, 32'h100);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("addi_valid", out_valid, 1);
    chk("addi_fmt", out_fmt, 1);
    chk("addi_rd", out_rd, 1);
    chk("addi_rs1", out_rs1, 0);
    chk("addi_imm", out_imm, 64'd5);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_opcode", out_opcode, 7'h13);
    chk("addi_illegal", out_illegal, 0);
    step();
    chk("addi_drained", out_valid, 0);

    // beq x0,x0,-4
    drive(1'b1, 32'hFE000EE3, 32'h104);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("beq_fmt", out_fmt, 4);
    chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_rs2", out_rs2, 0);
    chk("beq_func7", out_func7, 7'h7F);
    step();

    // lui x1,0x12345 then sw x2,8(x1) under a three-cycle stall
    out_ready = 1'b0;
    drive(1'b1, 32'h123450B7, 32'h200);
    step();
    chk("lui_valid", out_valid, 1);
    chk("lui_in_ready_one", in_ready, 1);
    chk("lui_fmt", out_fmt, 2);
    chk("lui_imm", out_imm, 64'h0000_0000_1234_5000);
    drive(1'b1, 32'h0020A423, 32'h204);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_pc_a", out_pc, 32'h200);
    step();
    chk("stall_pc_b", out_pc, 32'h200);
    chk("stall_imm_b", out_imm, 64'h0000_0000_1234_5000);
    chk("stall_valid_b", out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("sw_pc", out_pc, 32'h204);
    chk("sw_fmt", out_fmt, 5);
    chk("sw_imm", out_imm, 64'd8);
    chk("sw_func3", out_func3, 2);
    chk("sw_in_ready", in_ready, 1);
    step();
    chk("sw_drained", out_valid, 0);

    // flush with the buffer full
    out_ready = 1'b0;
    drive(1'b1, 32'h123450B7, 32'h300);
    step();
    drive(1'b1, 32'h0020A423, 32'h304);
    step();
    chk("two_in_ready", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 32'h00500093, 32'h308);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("flush_two_valid", out_valid, 0);
    chk("flush_two_in_ready", in_ready, 1);
    step();
    chk("flush_two_after", out_valid, 0);

    // flush in ONE drops the beat offered alongside it
    drive(1'b1, 32'h123450B7, 32'h400);
    step();
    flush = 1'b1;
    drive(1'b1, 32'h00500093, 32'h404);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("flush_one_valid", out_valid, 0);
    step();
    chk("flush_one_after", out_valid, 0);

    // back-to-back stream with out_ready high
    out_ready = 1'b1;
    drive(1'b1, 32'h00500093, 32'h500);
    step();
    drive(1'b1, 32'h40000033, 32'h504);
    chk("tp_pc0", out_pc, 32'h500);
    chk("tp_rdy0", in_ready, 1);
    step();
    drive(1'b1, 32'h0000007F, 32'h508);
    chk("tp_pc1", out_pc, 32'h504);
    chk("sub_fmt", out_fmt, 6);
    chk("sub_illegal", out_illegal, 0);
    step();
    drive(1'b1, 32'h40001033, 32'h50C);
`ifdef DECODE_ILLEGAL_CHK_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    chk("tp_pc2", out_pc, 32'h508);
    chk("bad_op_fmt", out_fmt, 0);
    chk("bad_op_imm", out_imm, 64'd0);
    chk("bad_op_illegal", out_illegal, exp_ill);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("sll30_fmt", out_fmt, 6);
    chk("sll30_illegal", out_illegal, exp_ill);
    step();
    chk("tp_drained", out_valid, 0);

    // asynchronous reset between edges
    out_ready = 1'b0;
    drive(1'b1, 32'h123450B7, 32'h600);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_illegal", out_illegal, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h00500093, 32'h700);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_imm", out_imm, 64'd5);
    chk("post_rst_pc", out_pc, 32'h700);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I decode stage sitting between the fetch unit and the register-read/execute stage. It accepts one instruction word plus its PC per cycle over a valid/ready handshake, splits the fields, classifies the format, builds the sign-extended immediate at XLEN width, and presents the result one cycle later. A two-entry output buffer (main plus skid) lets back-pressure stall fetch without a combinational ready path, and a flush input discards in-flight entries on branch redirect.

## Interface
- XLEN, 32: immediate and PC width. Legal values are 32 and 64. Immediates are sign-extended from bit 31 to XLEN.
- PC_W, 32: width of the PC side-band. Must satisfy PC_W ≤ XLEN.

Ports (name, direction, width, meaning):
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard both buffer entries and the input beat offered this cycle.
- in_valid  in  1  an instruction is offered.
- in_ready  out  1  the stage accepts a beat this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  the decoded beat is valid.
- out_ready  in  1  the downstream stage consumes the beat.
- out_opcode / out_func3 / out_func7  out  7/3/7  instr[6:0] / [14:12] / [31:25].
- out_rs1 / out_rs2 / out_rd  out  5 each  instr[19:15] / [24:20] / [11:7].
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  format: 0 none, 1 I, 2 U, 3 J, 4 B, 5 S, 6 R.
- out_pc  out  PC_W  PC carried alongside the beat.
- out_illegal  out  1  illegal-encoding flag. Tied to 0 when the feature is compiled out.

## Operation
- Opcode classes:
  - I: 1100111 (jalr), 0000011 (load), 0010011 (op-imm).
  - U: 0110111 (lui), 0010111 (auipc).
  - J: 1101111.
  - B: 1100011.
  - S: 0100011.
  - R: 0110011.
  - Anything else is fmt 0 with imm 0.
- Immediates, before extension to XLEN:
  - I = sext(instr[31:20]).
  - U = {instr[31:12], 12'b0}, sign-extended from bit 31.
  - J = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - B = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - S = sext({instr[31:25], instr[11:7]}).
- Decode is combinational on in_instr. The result plus in_pc is captured into the buffer.
- Buffer states:
  - EMPTY: out_valid = 0.
  - ONE: main entry valid.
  - TWO: main and skid entries valid.
- in_ready = (state != TWO). It is registered and does not depend on out_ready.
- Input accept = in_valid & in_ready & !flush. Output consume = out_valid & out_ready.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept & !consume → TWO; the new beat goes to skid.
  - ONE + accept & consume → ONE; the new beat replaces main.
  - ONE + consume only → EMPTY.
  - TWO + consume → ONE; skid moves to main. No accept is possible in TWO.
- Ordering is strictly FIFO. The outputs always reflect the main entry.
- flush:
  - The next state is EMPTY regardless of accept or consume.
  - A consume in the same cycle still completes from the downstream view.
  - out_valid = 0 from the following cycle.
- Datapath registers are not reset. Only the state register and the valid flags are reset.

## Timing
- Latency: an accept in cycle N gives out_valid with that beat in cycle N+1.
- Throughput: one beat per cycle while out_ready is held high.
- Reset (asynchronous assert, synchronous release):
  - state = EMPTY, out_valid = 0, in_ready = 1, out_illegal = 0.
  - All other outputs are don't-care while out_valid = 0.
- Reset asserted mid-operation drops both entries immediately, with no output glitch beyond out_valid falling.
- Outputs are stable while out_valid & !out_ready (no change under stall).

## Configuration
- DECODE_ILLEGAL_CHK_EN defined: out_illegal is set for the beat when any of the following holds:
  - instr[1:0] != 2'b11.
  - The opcode is unrecognised.
  - jalr with func3 != 000.
  - A B-type with func3 010 or 011.
  - A load with func3 011, 110 or 111.
  - A store with func3 > 010.
  - An R-type with func7 other than 0000000, or other than 0100000 for func3 000/101.
  - The illegal flag is buffered with the beat and obeys the same latency.
- DECODE_ILLEGAL_CHK_EN not defined: out_illegal is constant 0 and no check logic is built. All other behaviour is identical.

## Test plan
- Reset release, then feed 0x00500093 (addi x1,x0,5) with pc 0x100 → next cycle: out_valid=1, fmt=1, rd=1, rs1=0, imm=5, pc=0x100.
- Feed 0xFE000EE3 (beq x0,x0,-4) at XLEN=64 → imm=0xFFFF_FFFF_FFFF_FFFC, fmt=4.
- Stream lui 0x12345 then sw, holding out_ready=0 for 3 cycles → in_ready falls after 2 accepts, outputs stay stable; release → beats emerge in order, lui imm=0x12345000.
- Buffer in TWO, assert flush with in_valid=1 → out_valid=0 next cycle, in_ready=1, the offered beat is never emitted.
- With DECODE_ILLEGAL_CHK_EN: 0x0000007F → out_illegal=1, fmt=0, imm=0. Without it → out_illegal=0.
- Assert rst asynchronously mid-stream between edges → out_valid drops immediately, and the first beat after release decodes correctly.
